// File: rtl/bp_cfg_loader.sv
// Boot-time configuration loader: freezes each core, streams its CCE microcode
// from a synchronous ROM over the config network, then unfreezes it.
module bp_cfg_loader #(
    parameter int num_core_p              = 1,
    parameter int cfg_core_width_p        = 8,
    parameter int cfg_addr_width_p        = 16,
    parameter int cfg_data_width_p        = 32,
    parameter int num_cce_instr_ram_els_p = 256,
    localparam int lg_els_lp              = $clog2(num_cce_instr_ram_els_p)
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        start_i,
    output logic                        rom_v_o,
    output logic [lg_els_lp-1:0]        rom_addr_o,
    input  logic [cfg_data_width_p-1:0] rom_data_i,
    output logic                        cfg_v_o,
    input  logic                        cfg_ready_i,
    output logic [cfg_core_width_p-1:0] cfg_core_o,
    output logic [cfg_addr_width_p-1:0] cfg_addr_o,
    output logic [cfg_data_width_p-1:0] cfg_data_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic [2:0]                  debug_state
);

    // Handshake: a packet moves on a clock edge where cfg_v_o and cfg_ready_i are
    // both 1. cfg_v_o is decoded from the state register only, so it never depends
    // on cfg_ready_i, and it plus all fields stay frozen until that edge.

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FREEZE   = 3'd1,
        S_RD       = 3'd2,
        S_SEND     = 3'd3,
        S_UNFREEZE = 3'd4,
        S_DONE     = 3'd5
    } state_e;

    localparam logic [cfg_addr_width_p-1:0] freeze_addr_lp = cfg_addr_width_p'(16'h0001);
    localparam logic [cfg_addr_width_p-1:0] ucode_base_lp  = cfg_addr_width_p'(16'h8000);
    localparam logic [lg_els_lp-1:0]        last_word_lp   = lg_els_lp'(num_cce_instr_ram_els_p - 1);
    localparam logic [cfg_core_width_p-1:0] last_core_lp   = cfg_core_width_p'(num_core_p - 1);

    state_e                        state_r, state_n;
    logic [cfg_core_width_p-1:0]   core_r;
    logic [lg_els_lp-1:0]          word_r;
    logic [cfg_data_width_p-1:0]   hold_r;
    logic                          send_first_r;
    logic                          xfer;
    logic                          load_cnt, core_inc, word_inc, word_clr;

    assign cfg_v_o     = (state_r == S_FREEZE) || (state_r == S_SEND) || (state_r == S_UNFREEZE);
    assign xfer        = cfg_v_o && cfg_ready_i;
    assign busy_o      = cfg_v_o || (state_r == S_RD);
    assign done_o      = (state_r == S_DONE);
    assign cfg_core_o  = core_r;
    assign debug_state = state_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    always_comb begin
        state_n    = state_r;
        load_cnt   = 1'b0;
        core_inc   = 1'b0;
        word_inc   = 1'b0;
        word_clr   = 1'b0;
        rom_v_o    = 1'b0;
        rom_addr_o = '0;
        cfg_addr_o = '0;
        cfg_data_o = '0;
        case (state_r)
            S_IDLE: begin
                if (start_i) begin
                    load_cnt = 1'b1;
                    state_n  = S_FREEZE;
                end
            end
            S_FREEZE: begin
                cfg_addr_o = freeze_addr_lp;
                cfg_data_o = cfg_data_width_p'(1);
                if (xfer) state_n = S_RD;
            end
            S_RD: begin
                rom_v_o    = 1'b1;
                rom_addr_o = word_r;
                state_n    = S_SEND;
            end
            S_SEND: begin
                cfg_addr_o = ucode_base_lp + cfg_addr_width_p'(word_r);
                // ROM answers in the first SEND cycle; afterwards the held copy is shown
                cfg_data_o = send_first_r ? rom_data_i : hold_r;
                if (xfer) begin
                    if (word_r == last_word_lp) begin
                        state_n = S_UNFREEZE;
                    end else begin
                        word_inc = 1'b1;
                        state_n  = S_RD;
                    end
                end
            end
            S_UNFREEZE: begin
                cfg_addr_o = freeze_addr_lp;
                if (xfer) begin
                    if (core_r == last_core_lp) begin
                        state_n = S_DONE;
                    end else begin
                        core_inc = 1'b1;
                        word_clr = 1'b1;
                        state_n  = S_FREEZE;
                    end
                end
            end
            S_DONE: begin
                state_n = S_DONE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            core_r       <= '0;
            word_r       <= '0;
            hold_r       <= '0;
            send_first_r <= 1'b0;
        end else begin
            send_first_r <= (state_r == S_RD);
            if (send_first_r) hold_r <= rom_data_i;
            if (load_cnt) begin
                core_r <= '0;
                word_r <= '0;
            end else begin
                if (core_inc) core_r <= core_r + cfg_core_width_p'(1);
                if (word_clr) begin
                    word_r <= '0;
                end else if (word_inc) begin
                    word_r <= word_r + lg_els_lp'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_bp_cfg_loader.sv
// Bench for bp_cfg_loader: a 1-core and a 2-core instance (4 microcode words each)
// against a queue-based model of the expected config packet stream.
module tb_bp_cfg_loader;

    localparam int els = 4;
    localparam int lg  = 2;
    localparam int cw  = 8;
    localparam int aw  = 16;
    localparam int dw  = 32;
    localparam int pw  = cw + aw + dw;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic          start_a, rom_v_a, cfg_v_a, ready_a, busy_a, done_a;
    logic [lg-1:0] rom_addr_a;
    logic [dw-1:0] rom_data_a, cfg_data_a;
    logic [cw-1:0] cfg_core_a;
    logic [aw-1:0] cfg_addr_a;
    logic [2:0]    st_a;

    logic          start_b, rom_v_b, cfg_v_b, ready_b, busy_b, done_b;
    logic [lg-1:0] rom_addr_b;
    logic [dw-1:0] rom_data_b, cfg_data_b;
    logic [cw-1:0] cfg_core_b;
    logic [aw-1:0] cfg_addr_b;
    logic [2:0]    st_b;

    bp_cfg_loader #(.num_core_p(1), .cfg_core_width_p(cw), .cfg_addr_width_p(aw),
                    .cfg_data_width_p(dw), .num_cce_instr_ram_els_p(els)) dut_a (
        .clk_i(clk), .reset_n_i(rst_n), .start_i(start_a),
        .rom_v_o(rom_v_a), .rom_addr_o(rom_addr_a), .rom_data_i(rom_data_a),
        .cfg_v_o(cfg_v_a), .cfg_ready_i(ready_a), .cfg_core_o(cfg_core_a),
        .cfg_addr_o(cfg_addr_a), .cfg_data_o(cfg_data_a),
        .busy_o(busy_a), .done_o(done_a), .debug_state(st_a));

    bp_cfg_loader #(.num_core_p(2), .cfg_core_width_p(cw), .cfg_addr_width_p(aw),
                    .cfg_data_width_p(dw), .num_cce_instr_ram_els_p(els)) dut_b (
        .clk_i(clk), .reset_n_i(rst_n), .start_i(start_b),
        .rom_v_o(rom_v_b), .rom_addr_o(rom_addr_b), .rom_data_i(rom_data_b),
        .cfg_v_o(cfg_v_b), .cfg_ready_i(ready_b), .cfg_core_o(cfg_core_b),
        .cfg_addr_o(cfg_addr_b), .cfg_data_o(cfg_data_b),
        .busy_o(busy_b), .done_o(done_b), .debug_state(st_b));

    // Synchronous microcode ROM shared by both instances
    logic [dw-1:0] rom_mem [els];
    always @(posedge clk) if (rom_v_a) rom_data_a <= rom_mem[rom_addr_a];
    always @(posedge clk) if (rom_v_b) rom_data_b <= rom_mem[rom_addr_b];

    logic [pw-1:0] exp_a[$];
    logic [pw-1:0] exp_b[$];
    int n_cmp = 0;
    int n_bad = 0;
    int xfer_b = 0;
    bit rand_mode = 0;
    time t0_a, t0_b;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event not seen within its cycle budget", name);
    endtask

    function automatic logic [63:0] outs_a();
        return {2'b0, cfg_v_a, cfg_core_a, cfg_addr_a, cfg_data_a, rom_v_a, rom_addr_a, busy_a, done_a};
    endfunction

    function automatic logic [63:0] outs_b();
        return {2'b0, cfg_v_b, cfg_core_b, cfg_addr_b, cfg_data_b, rom_v_b, rom_addr_b, busy_b, done_b};
    endfunction

    // Reference model: freeze, every microcode word, unfreeze -- per core, in order
    task automatic push_seq(input int which, input int ncore);
        logic [pw-1:0] p;
        for (int c = 0; c < ncore; c++) begin
            p = {cw'(c), 16'h0001, 32'd1};
            if (which == 0) exp_a.push_back(p); else exp_b.push_back(p);
            for (int w = 0; w < els; w++) begin
                p = {cw'(c), 16'(32'h8000 + w), rom_mem[w]};
                if (which == 0) exp_a.push_back(p); else exp_b.push_back(p);
            end
            p = {cw'(c), 16'h0001, 32'd0};
            if (which == 0) exp_a.push_back(p); else exp_b.push_back(p);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (cfg_v_a && ready_a) begin
                if (exp_a.size() == 0) fail("unexpected_xfer_a");
                else check("xfer_a", {cfg_core_a, cfg_addr_a, cfg_data_a}, exp_a.pop_front());
            end
            if (rom_v_a) check("rom_v_while_valid_a", cfg_v_a, 0);
        end
    end

    logic [pw-1:0] mon_pkt_b, prev_pkt_b;
    bit prev_stall_b = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall_b = 0;
        end else begin
            mon_pkt_b = {cfg_core_b, cfg_addr_b, cfg_data_b};
            if (prev_stall_b) check("stall_hold_b", {cfg_v_b, mon_pkt_b}, {1'b1, prev_pkt_b});
            if (cfg_v_b && ready_b) begin
                xfer_b++;
                if (exp_b.size() == 0) fail("unexpected_xfer_b");
                else check("xfer_b", mon_pkt_b, exp_b.pop_front());
            end
            if (rom_v_b) check("rom_v_while_valid_b", cfg_v_b, 0);
            prev_stall_b = cfg_v_b && !ready_b;
            prev_pkt_b   = mon_pkt_b;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_mode) ready_b = ($urandom_range(0, 1) == 1);
    end

    task automatic start_pulse_b();
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); t0_b = $time;
        #1 start_b = 1'b0;
        xfer_b = 0;
    endtask

    task automatic wait_done_b(input int budget, output int cyc);
        int k = 0;
        while (!done_b && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        if (!done_b) fail("done_timeout_b");
        cyc = int'(($time - t0_b - 1) / 10);
    endtask

    task automatic do_reset();
        @(negedge clk) rst_n = 1'b0;
        exp_b.delete();
        @(negedge clk);
        check("reset_outs_b", outs_b(), 0);
        rst_n = 1'b1;
    endtask

    initial begin
        int n, k, cyc;
        time t_rand;
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; ready_a = 1'b1; ready_b = 1'b1;
        for (int w = 0; w < els; w++) rom_mem[w] = 32'hA0 + w;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs_a", outs_a(), 0);
        check("reset_outs_b", outs_b(), 0);
        @(negedge clk) rst_n = 1'b1;

        // Single core, ready always high: exact stream and 10-cycle latency
        push_seq(0, 1);
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); t0_a = $time;
        #1 start_a = 1'b0;
        n = 0;
        while (!done_a && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_latency_a", n, 10);
        check("exp_a_drained", exp_a.size(), 0);
        check("busy_in_done_a", busy_a, 0);

        // Two cores, start pulsed during SEND and again in DONE
        push_seq(1, 2);
        start_pulse_b();
        k = 0;
        while (!(cfg_v_b && cfg_addr_b == 16'h8001) && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (k == 50) fail("reach_send_b");
        start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        wait_done_b(200, cyc);
        check("done_latency_2core", cyc, 20);
        check("xfers_at_done", xfer_b, 12);
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("done_sticky_after_start", {busy_b, done_b, cfg_v_b}, 3'b010);
        check("exp_b_drained_1", exp_b.size(), 0);

        // Five-cycle backpressure on core 0 word 2
        do_reset();
        push_seq(1, 2);
        start_pulse_b();
        k = 0;
        while (!(cfg_v_b && cfg_addr_b == 16'h8002 && cfg_core_b == 0) && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (k == 50) fail("reach_word2_b");
        ready_b = 1'b0;
        repeat (5) @(posedge clk);
        #1 ready_b = 1'b1;
        wait_done_b(200, cyc);
        check("done_latency_stall", cyc, 25);
        check("exp_b_drained_2", exp_b.size(), 0);

        // Asynchronous reset in RD of core 0 word 1, then a clean restart
        do_reset();
        push_seq(1, 2);
        start_pulse_b();
        k = 0;
        while (!(rom_v_b && rom_addr_b == 2'd1) && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (k == 50) fail("reach_rd1_b");
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outs_b", outs_b(), 0);
        check("async_reset_outs_a", outs_a(), 0);
        exp_b.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_after_reset", {busy_b, done_b, cfg_v_b}, 3'b000);
        push_seq(1, 2);
        start_pulse_b();
        wait_done_b(200, cyc);
        check("done_latency_restart", cyc, 20);
        check("exp_b_drained_3", exp_b.size(), 0);

        // Random backpressure and random ROM contents for at least 1000 cycles
        t_rand = $time;
        rand_mode = 1;
        while ($time - t_rand < 10000) begin
            do_reset();
            for (int w = 0; w < els; w++) rom_mem[w] = $urandom;
            push_seq(1, 2);
            start_pulse_b();
            wait_done_b(2000, cyc);
            check("rand_xfers", xfer_b, 12);
            check("rand_exp_drained", exp_b.size(), 0);
        end
        rand_mode = 0;
        #1 ready_b = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bp_cfg_loader.md
BP_CFG_LOADER -- requirements
Module: bp_cfg_loader

Interface
REQ-001 The block SHALL have parameter num_core_p, default 1, meaning the number of cores to configure, with core IDs 0..num_core_p-1.
REQ-002 The block SHALL have parameter cfg_core_width_p, default 8, meaning the width of the core-ID field.
REQ-003 The block SHALL have parameter cfg_addr_width_p, default 16, meaning the width of the config-register address.
REQ-004 The block SHALL have parameter cfg_data_width_p, default 32, meaning the width of the config data.
REQ-005 The block SHALL have parameter num_cce_instr_ram_els_p, default 256, meaning the number of CCE microcode words loaded per core; lg_els = clog2(num_cce_instr_ram_els_p).
REQ-006 The block SHALL have port clk_i, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-007 The block SHALL have port reset_n_i, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-008 The block SHALL have port start_i, input, 1 bit: a one-cycle pulse that begins a load sequence.
REQ-009 The block SHALL have port rom_v_o, output, 1 bit: the microcode ROM read strobe.
REQ-010 The block SHALL have port rom_addr_o, output, lg_els bits: the microcode ROM word index.
REQ-011 The block SHALL have port rom_data_i, input, cfg_data_width_p bits: ROM read data, valid exactly 1 cycle after rom_v_o.
REQ-012 The block SHALL have port cfg_v_o, output, 1 bit: config packet valid.
REQ-013 The block SHALL have port cfg_ready_i, input, 1 bit: the downstream config network accepts the packet.
REQ-014 The block SHALL have port cfg_core_o, output, cfg_core_width_p bits: the target core ID.
REQ-015 The block SHALL have port cfg_addr_o, output, cfg_addr_width_p bits: the config-register address.
REQ-016 The block SHALL have port cfg_data_o, output, cfg_data_width_p bits: the config write data.
REQ-017 The block SHALL have port busy_o, output, 1 bit: a sequence is in progress.
REQ-018 The block SHALL have port done_o, output, 1 bit: sticky, set when all cores are configured.

Function
REQ-019 The FSM SHALL have the states IDLE, FREEZE, RD, SEND, UNFREEZE, DONE.
REQ-020 In IDLE, start_i=1 SHALL go to FREEZE with core counter=0 and word counter=0; start_i SHALL be ignored in every other state.
REQ-021 In FREEZE, the block SHALL present core=counter, addr=0x0001, data=1; on transfer it SHALL go to RD.
REQ-022 In RD, the block SHALL assert rom_v_o for exactly 1 cycle with rom_addr_o=word counter, then go to SEND.
REQ-023 Entering SEND, the block SHALL capture rom_data_i into a holding register, and SHALL present addr=0x8000+word and data=the held value.
REQ-024 On a SEND transfer, if word < els-1 the block SHALL increment word and return to RD; otherwise it SHALL go to UNFREEZE.
REQ-025 In UNFREEZE, the block SHALL present addr=0x0001, data=0; on transfer, if core < num_core_p-1 it SHALL increment core, clear word, and go to FREEZE; otherwise it SHALL go to DONE.
REQ-026 DONE SHALL be terminal: done_o=1, busy_o=0, and the block SHALL leave DONE only on reset.
REQ-027 A transfer SHALL occur only when cfg_v_o and cfg_ready_i are both 1 in the same cycle.
REQ-028 cfg_v_o SHALL be 1 only in FREEZE, SEND, and UNFREEZE.
REQ-029 While cfg_v_o=1 and cfg_ready_i=0, cfg_core_o, cfg_addr_o, and cfg_data_o SHALL be held stable; cfg_v_o SHALL NOT drop before a transfer.
REQ-030 cfg_v_o SHALL be registered and SHALL NOT depend combinationally on cfg_ready_i.
REQ-031 busy_o SHALL be 1 in FREEZE, RD, SEND, and UNFREEZE.
REQ-032 cfg_core_o SHALL be the core counter zero-extended to cfg_core_width_p.
REQ-033 The address add 0x8000+word SHALL be performed at cfg_addr_width_p bits with no carry-out.
REQ-034 The word counter SHALL NOT wrap; the transition at els-1 is governed by REQ-024.
REQ-035 With cfg_ready_i held at 1, the sequence for one core SHALL take 1 + 2*els + 1 cycles from entering FREEZE to leaving UNFREEZE.
REQ-036 rom_v_o SHALL be 0 in every state except RD.

Reset
REQ-037 While reset_n_i=0, the block SHALL be in IDLE with both counters=0 and the holding register=0.
REQ-038 While reset_n_i=0, all outputs SHALL be 0: cfg_v_o, cfg_core_o, cfg_addr_o, cfg_data_o, rom_v_o, rom_addr_o, busy_o, done_o.
REQ-039 Reset asserted mid-sequence SHALL abort the sequence immediately and asynchronously; no partial state SHALL be retained.
REQ-040 After reset_n_i deasserts, the block SHALL wait for a new start_i.

Verification
REQ-041 Scenario: num_core_p=1, els=4, ROM word i=0xA0+i, ready always 1 -> the bench SHALL see transfers (0,0x0001,1), (0,0x8000,0xA0), (0,0x8001,0xA1), (0,0x8002,0xA2), (0,0x8003,0xA3), (0,0x0001,0), then done_o=1 exactly 10 cycles after FREEZE entry.
REQ-042 Scenario: num_core_p=2, els=4 -> the bench SHALL see 12 transfers, with core 1's FREEZE immediately after core 0's UNFREEZE, and done_o=1 only after the 12th transfer.
REQ-043 Scenario: cfg_ready_i=0 for 5 cycles during SEND of word 2 -> the bench SHALL see cfg_v_o=1 with fields unchanged, no further rom_v_o, and resumption on ready.
REQ-044 Scenario: start_i pulsed during SEND and again in DONE -> the bench SHALL see no effect; the sequence and done_o are unchanged.
REQ-045 Scenario: reset_n_i=0 asserted asynchronously in RD of core 0, word 1 -> all outputs SHALL be 0 without a clock edge; the next start_i SHALL restart from (0,0x0001,1).
REQ-046 Scenario: randomized cfg_ready_i for 1000 cycles -> the bench SHALL see the transfer sequence identical to the ready-always-1 case and no cfg_v_o drop without a transfer.
